// File: rtl/branch_ctrl.sv
// Branch resolution controller: 2-bit saturating-counter direction predictor,
// EX-stage resolution and a redirect-then-flush sequencer on mispredicts.
module branch_ctrl #(
   parameter int unsigned IDX_W        = 4,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [15:0] CNT_SAT      = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] fetch_pc,
   output logic        pred_taken,
   input  logic        ex_valid,
   input  logic [6:0]  ex_opc,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_rs1,
   input  logic        ex_cond,
   input  logic        ex_pred_taken,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        busy,
   output logic [15:0] mispredict_cnt
);

   localparam int unsigned DEPTH      = 2 ** IDX_W;
   localparam int unsigned FC_W       = 4;
   localparam int unsigned FLUSH_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REDIRECT = 2'd1,
      S_FLUSH    = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [FC_W-1:0]   fcnt_q, fcnt_d;
   logic              redirect_d, flush_d, busy_d;
   logic [31:0]       redirect_pc_d;
   logic [15:0]       mcnt_d;
   logic [1:0]        ctr_q [DEPTH];
   logic [IDX_W-1:0]  fetch_idx, ex_idx;
   logic              accept, is_branch, taken, mispredict;
   logic [31:0]       target, next_pc;
   logic              unused_fetch_bits;

   assign fetch_idx         = fetch_pc[IDX_W+1:2];
   assign ex_idx            = ex_pc[IDX_W+1:2];
   assign pred_taken        = ctr_q[fetch_idx][1];
   assign unused_fetch_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};
   assign is_branch         = (ex_opc == OPC_BRANCH);
   assign accept            = ex_valid && (state_q == S_IDLE);

   // Resolve direction, target and mispredict for the EX instruction.
   always_comb begin
      taken      = 1'b0;
      mispredict = 1'b0;
      target     = ex_pc + ex_imm;
      if (is_branch) begin
         taken      = ex_cond;
         mispredict = (ex_cond != ex_pred_taken);
      end else if (ex_opc == OPC_JAL) begin
         taken      = 1'b1;
         mispredict = !ex_pred_taken;
      end else if (ex_opc == OPC_JALR) begin
         taken      = 1'b1;
         target     = (ex_rs1 + ex_imm) & ~32'h1;
         mispredict = 1'b1;
      end
      next_pc = taken ? target : ex_pc + 32'd4;
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d       = state_q;
      fcnt_d        = fcnt_q;
      redirect_pc_d = redirect_pc;
      mcnt_d        = mispredict_cnt;
      case (state_q)
         S_IDLE: begin
            if (accept && mispredict) begin
               state_d       = S_REDIRECT;
               redirect_pc_d = next_pc;
               if (mispredict_cnt != CNT_SAT) mcnt_d = mispredict_cnt + 16'd1;
            end
         end
         S_REDIRECT: begin
            if (FLUSH_CYCLES > 1) begin
               state_d = S_FLUSH;
               fcnt_d  = FC_W'(FLUSH_LOAD);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (fcnt_q == '0) state_d = S_IDLE;
            else              fcnt_d  = fcnt_q - FC_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
      redirect_d = (state_d == S_REDIRECT);
      flush_d    = (state_d != S_IDLE);
      busy_d     = flush_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         fcnt_q         <= '0;
         redirect       <= 1'b0;
         flush          <= 1'b0;
         busy           <= 1'b0;
         redirect_pc    <= '0;
         mispredict_cnt <= '0;
      end else begin
         state_q        <= state_d;
         fcnt_q         <= fcnt_d;
         redirect       <= redirect_d;
         flush          <= flush_d;
         busy           <= busy_d;
         redirect_pc    <= redirect_pc_d;
         mispredict_cnt <= mcnt_d;
      end
   end

   // History table: resets weakly not-taken, trains on accepted branches only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
      end else if (accept && is_branch) begin
         if (ex_cond) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
         end else begin
            if (ctr_q[ex_idx] != 2'b00) ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
         end
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized
// traffic against a cycle-count reference model.
module tb_branch_ctrl;

   localparam int         F0   = 2;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fetch_pc, ex_pc, ex_imm, ex_rs1;
   logic [6:0]  ex_opc;
   logic        ex_valid, ex_valid1, ex_cond, ex_pred_taken;
   logic        pred_taken, redirect, flush, busy;
   logic [31:0] redirect_pc;
   logic [15:0] mcnt;
   logic        pred_taken1, redirect1, flush1, busy1;
   logic [31:0] redirect_pc1;
   logic [15:0] mcnt1;

   int n_cmp, n_bad;

   // reference model state
   int          m_tab [16];
   int          m_phase;
   logic [31:0] m_rpc;
   int          m_cnt;
   logic        exp_redir, exp_flush, exp_busy, exp_pred;
   logic [31:0] exp_rpc;
   logic [15:0] exp_cnt;

   always #5 clk = ~clk;

   branch_ctrl #(.IDX_W(4), .FLUSH_CYCLES(F0)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_opc(ex_opc), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_cond(ex_cond), .ex_pred_taken(ex_pred_taken),
      .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
      .busy(busy), .mispredict_cnt(mcnt));

   branch_ctrl #(.IDX_W(4), .FLUSH_CYCLES(1), .CNT_SAT(16'd5)) dut1 (
      .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken1),
      .ex_valid(ex_valid1), .ex_opc(ex_opc), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_cond(ex_cond), .ex_pred_taken(ex_pred_taken),
      .redirect(redirect1), .redirect_pc(redirect_pc1), .flush(flush1),
      .busy(busy1), .mispredict_cnt(mcnt1));

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_tab[i] = 1;
      m_phase = 0;
      m_rpc   = '0;
      m_cnt   = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ex_valid = 1'b0; ex_valid1 = 1'b0; ex_opc = '0;
      ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_cond = 1'b0;
      ex_pred_taken = 1'b0; fetch_pc = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one cycle of inputs and compute the outputs expected this cycle.
   task automatic set_in(input logic v, input logic [6:0] opc, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic cond,
                         input logic pt, input logic [31:0] fpc);
      ex_valid = v; ex_opc = opc; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
      ex_cond = cond; ex_pred_taken = pt; fetch_pc = fpc;
      #1;
      exp_redir = (m_phase == F0);
      exp_flush = (m_phase > 0);
      exp_busy  = (m_phase > 0);
      exp_rpc   = m_rpc;
      exp_cnt   = 16'(m_cnt);
      exp_pred  = (m_tab[int'(fpc[5:2])] >= 2);
   endtask

   // Apply the architectural effect of this cycle's inputs, then move to next cycle.
   task automatic adv();
      logic        tk, mp, act;
      logic [31:0] tgt;
      int          idx;
      if (m_phase > 0) begin
         m_phase--;
      end else if (ex_valid) begin
         act = 1'b1; tk = 1'b1; mp = 1'b0; tgt = ex_pc + ex_imm;
         case (ex_opc)
            BR: begin
               tk  = ex_cond;
               mp  = (ex_cond != ex_pred_taken);
               idx = int'(ex_pc[5:2]);
               if (ex_cond) m_tab[idx] = (m_tab[idx] < 3) ? m_tab[idx] + 1 : 3;
               else         m_tab[idx] = (m_tab[idx] > 0) ? m_tab[idx] - 1 : 0;
            end
            JAL:  mp = !ex_pred_taken;
            JALR: begin
               tgt = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
               mp  = 1'b1;
            end
            default: act = 1'b0;
         endcase
         if (act && mp) begin
            m_phase = F0;
            m_rpc   = tk ? tgt : ex_pc + 32'd4;
            if (m_cnt < 65535) m_cnt++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      set_in(1'b0, 7'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h40);
      n_cmp++;
      if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL reset_pred got %b exp 0", pred_taken); end
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b000) begin
         n_bad++; $display("FAIL reset_ctrl got %b exp 000", {redirect, flush, busy});
      end
      n_cmp++;
      if (redirect_pc !== 32'h0 || mcnt !== 16'h0) begin
         n_bad++; $display("FAIL reset_regs got rpc=%h cnt=%h exp 0/0", redirect_pc, mcnt);
      end
      n_cmp++;
      if ({pred_taken1, redirect1, flush1, busy1} !== 4'b0000 || mcnt1 !== 16'h0) begin
         n_bad++; $display("FAIL reset_dut1 got %b cnt=%h exp 0000/0",
                           {pred_taken1, redirect1, flush1, busy1}, mcnt1);
      end
      adv();
   endtask

   task automatic test_branch_mispredict();
      set_in(1'b1, BR, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 32'h100);
      n_cmp++;
      if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL br_old_pred got %b exp 0", pred_taken); end
      adv();
      set_in(1'b0, 7'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b111) begin
         n_bad++; $display("FAIL br_n1_ctrl got %b exp 111", {redirect, flush, busy});
      end
      n_cmp++;
      if (redirect_pc !== 32'h120) begin n_bad++; $display("FAIL br_rpc got %h exp 00000120", redirect_pc); end
      n_cmp++;
      if (mcnt !== 16'd1) begin n_bad++; $display("FAIL br_cnt got %0d exp 1", mcnt); end
      n_cmp++;
      if (pred_taken !== 1'b1) begin n_bad++; $display("FAIL br_new_pred got %b exp 1", pred_taken); end
      adv();
      set_in(1'b0, 7'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b011) begin
         n_bad++; $display("FAIL br_n2_ctrl got %b exp 011", {redirect, flush, busy});
      end
      adv();
   endtask

   task automatic test_jal_jalr_busy();
      set_in(1'b1, JALR, 32'h300, 32'h4, 32'h2001, 1'b0, 1'b1, 32'h100);
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b000) begin
         n_bad++; $display("FAIL jalr_accept_ctrl got %b exp 000", {redirect, flush, busy});
      end
      adv();
      set_in(1'b0, 7'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b111 || redirect_pc !== 32'h2004) begin
         n_bad++; $display("FAIL jalr_redirect got %b rpc=%h exp 111 rpc=00002004",
                           {redirect, flush, busy}, redirect_pc);
      end
      adv();
      // mispredicting branch offered while flushing must be dropped
      set_in(1'b1, BR, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1, 32'h100);
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b011) begin
         n_bad++; $display("FAIL jalr_flush_ctrl got %b exp 011", {redirect, flush, busy});
      end
      adv();
      set_in(1'b1, JAL, 32'h400, 32'h80, 32'h0, 1'b0, 1'b1, 32'h100);
      n_cmp++;
      if (mcnt !== 16'd2 || pred_taken !== 1'b1) begin
         n_bad++; $display("FAIL busy_ignore got cnt=%0d pred=%b exp 2/1", mcnt, pred_taken);
      end
      adv();
      set_in(1'b0, 7'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b000 || redirect_pc !== 32'h2004) begin
         n_bad++; $display("FAIL jal_correct got %b rpc=%h exp 000 rpc=00002004",
                           {redirect, flush, busy}, redirect_pc);
      end
      adv();
   endtask

   task automatic test_back_to_back();
      logic [9:0] conds;
      logic [9:0] preds;
      conds = 10'b00_1111_0000;
      preds = 10'b11_1100_0000;
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, BR, 32'h4, 32'h40, 32'h0, conds[i], conds[i], 32'h4);
         n_cmp++;
         if ({redirect, flush, busy} !== 3'b000 || pred_taken !== preds[i]) begin
            n_bad++; $display("FAIL b2b_%0d got ctrl=%b pred=%b exp 000/%b",
                              i, {redirect, flush, busy}, pred_taken, preds[i]);
         end
         adv();
      end
      set_in(1'b0, 7'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4);
      n_cmp++;
      if (pred_taken !== 1'b0 || mcnt !== 16'd2) begin
         n_bad++; $display("FAIL b2b_final got pred=%b cnt=%0d exp 0/2", pred_taken, mcnt);
      end
      adv();
   endtask

   task automatic test_reset_mid_redirect();
      set_in(1'b1, JALR, 32'h0, 32'h8, 32'h500, 1'b0, 1'b0, 32'h100);
      adv();
      set_in(1'b0, 7'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b111) begin
         n_bad++; $display("FAIL rst_mid_pre got %b exp 111", {redirect, flush, busy});
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({redirect, flush, busy} !== 3'b000 || pred_taken !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid_ctrl got %b pred=%b exp 000/0",
                           {redirect, flush, busy}, pred_taken);
      end
      n_cmp++;
      if (mcnt !== 16'h0 || redirect_pc !== 32'h0) begin
         n_bad++; $display("FAIL rst_mid_regs got cnt=%h rpc=%h exp 0/0", mcnt, redirect_pc);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_flush1();
      ex_valid = 1'b0; ex_valid1 = 1'b1; ex_opc = JALR; ex_pc = 32'h0;
      ex_rs1 = 32'h1000; ex_imm = 32'h10; ex_cond = 1'b0; ex_pred_taken = 1'b1;
      for (int k = 0; k < 20; k++) begin
         logic [2:0]  ectrl;
         logic [15:0] ecnt;
         #1;
         ectrl = (k % 2 == 1) ? 3'b111 : 3'b000;
         ecnt  = 16'(((k + 1) / 2 < 5) ? (k + 1) / 2 : 5);
         n_cmp++;
         if ({redirect1, flush1, busy1} !== ectrl || mcnt1 !== ecnt) begin
            n_bad++; $display("FAIL f1_cyc%0d got ctrl=%b cnt=%0d exp %b/%0d",
                              k, {redirect1, flush1, busy1}, mcnt1, ectrl, ecnt);
         end
         if (k % 2 == 1) begin
            n_cmp++;
            if (redirect_pc1 !== 32'h1010) begin
               n_bad++; $display("FAIL f1_rpc%0d got %h exp 00001010", k, redirect_pc1);
            end
         end
         @(negedge clk);
      end
      ex_valid1 = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [6:0] opc;
         int         sel;
         sel = int'($urandom_range(0, 7));
         if (sel < 4)       opc = BR;
         else if (sel == 4) opc = JAL;
         else if (sel == 5) opc = JALR;
         else               opc = 7'($urandom_range(0, 127));
         set_in($urandom_range(0, 3) != 0, opc, 32'($urandom_range(0, 255)) << 2,
                $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)) << 2);
         n_cmp++;
         if ({redirect, flush, busy} !== {exp_redir, exp_flush, exp_busy}) begin
            n_bad++; $display("FAIL rnd_ctrl c%0d got %b exp %b", c,
                              {redirect, flush, busy}, {exp_redir, exp_flush, exp_busy});
         end
         n_cmp++;
         if (redirect_pc !== exp_rpc || mcnt !== exp_cnt) begin
            n_bad++; $display("FAIL rnd_regs c%0d got rpc=%h cnt=%0d exp rpc=%h cnt=%0d",
                              c, redirect_pc, mcnt, exp_rpc, exp_cnt);
         end
         n_cmp++;
         if (pred_taken !== exp_pred) begin
            n_bad++; $display("FAIL rnd_pred c%0d got %b exp %b", c, pred_taken, exp_pred);
         end
         adv();
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      do_reset();
      test_reset();
      test_branch_mispredict();
      test_jal_jalr_busy();
      test_back_to_back();
      test_reset_mid_redirect();
      test_flush1();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
